// File: rtl/dzmmu.sv
// Game Boy memory-management unit: address decode, boot-ROM latch, IE, WRAM/HRAM
// and the FF46 OAM DMA engine sitting between the CPU bus and the devices.
module dzmmu #(
    parameter int WRAM_AW = 13,
    parameter int DMA_LEN = 160
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iMCUAddr,
    input  logic [7:0]  iMCUData,
    input  logic        iMCUwe,
    output logic [7:0]  oMCUData,
    output logic [7:0]  oBootAddr,
    input  logic [7:0]  iBootData,
    output logic [15:0] oCartAddr,
    input  logic [7:0]  iCartData,
    output logic [7:0]  oCartData,
    output logic        oCartWe,
    output logic [12:0] oVramAddr,
    input  logic [7:0]  iVramData,
    output logic [7:0]  oVramData,
    output logic        oVramWe,
    output logic [7:0]  oOamAddr,
    input  logic [7:0]  iOamData,
    output logic [7:0]  oOamData,
    output logic        oOamWe,
    output logic [6:0]  oIoAddr,
    input  logic [7:0]  iIoData,
    output logic [7:0]  oIoData,
    output logic        oIoWe,
    output logic [7:0]  oIE,
    output logic        oDmaActive
);
    typedef enum logic [1:0] {IDLE, RD, WR} dma_state_t;

    dma_state_t state;
    logic       boot_dis;
    logic [7:0] ie, page, cnt, dma_byte, rdata, rd_next, src_data;
    logic [7:0] wram [0:(1<<WRAM_AW)-1];
    logic [7:0] hram [0:127];

    logic [15:0] a, src;
    logic dma_on, dma_wr, we, cpu_we;
    logic is_cart, is_vram, is_wram, is_oam, is_gap, is_io, is_dmareg, is_bootreg, is_hram, is_ie;

    assign a      = iMCUAddr;
    assign src    = {page, cnt};
    assign dma_on = (state != IDLE);
    // Reset kills every strobe in the cycle it is asserted, including a pending DMA write.
    assign dma_wr = (state == WR) && !iReset;
    assign we     = iMCUwe && !iReset;
    assign cpu_we = we && !dma_on;

    assign is_cart    = !a[15] || (a[15:13] == 3'b101);
    assign is_vram    = (a[15:13] == 3'b100);
    assign is_wram    = (a >= 16'hC000) && (a < 16'hFE00);
    assign is_oam     = (a >= 16'hFE00) && (a < 16'hFEA0);
    assign is_gap     = (a >= 16'hFEA0) && (a < 16'hFF00);
    assign is_io      = (a[15:7] == 9'h1FE);
    assign is_dmareg  = (a == 16'hFF46);
    assign is_bootreg = (a == 16'hFF50);
    assign is_hram    = (a >= 16'hFF80) && (a != 16'hFFFF);
    assign is_ie      = (a == 16'hFFFF);

    assign oBootAddr  = a[7:0];
    assign oCartAddr  = dma_on ? src : a;
    assign oCartData  = iMCUData;
    assign oCartWe    = cpu_we && is_cart;
    assign oVramAddr  = dma_on ? src[12:0] : a[12:0];
    assign oVramData  = iMCUData;
    assign oVramWe    = cpu_we && is_vram;
    assign oOamAddr   = dma_on ? cnt : a[7:0];
    assign oOamData   = dma_on ? dma_byte : iMCUData;
    assign oOamWe     = dma_wr || (cpu_we && is_oam);
    assign oIoAddr    = a[6:0];
    assign oIoData    = iMCUData;
    assign oIoWe      = cpu_we && is_io && !is_dmareg && !is_bootreg;
    assign oIE        = ie;
    assign oDmaActive = dma_on;
    assign oMCUData   = rdata;

    // DMA source: pages C0 and up (including the echo) come from internal WRAM.
    always_comb begin
        src_data = iCartData;
        if (page >= 8'hC0)
            src_data = wram[src[WRAM_AW-1:0]];
        else if (page[7:5] == 3'b100)
            src_data = iVramData;
    end

    always_comb begin
        rd_next = 8'hFF;
        if (dma_on) begin
            if (is_hram)    rd_next = hram[a[6:0]];
            else if (is_ie) rd_next = ie;
        end else if (a < 16'h0100 && !boot_dis) rd_next = iBootData;
        else if (is_cart)    rd_next = iCartData;
        else if (is_vram)    rd_next = iVramData;
        else if (is_wram)    rd_next = wram[a[WRAM_AW-1:0]];
        else if (is_oam)     rd_next = iOamData;
        else if (is_gap)     rd_next = 8'h00;
        else if (is_dmareg)  rd_next = page;
        else if (is_bootreg) rd_next = {7'h7F, boot_dis};
        else if (is_io)      rd_next = iIoData;
        else if (is_hram)    rd_next = hram[a[6:0]];
        else if (is_ie)      rd_next = ie;
    end

    always_ff @(posedge iClock) begin
        if (cpu_we && is_wram) wram[a[WRAM_AW-1:0]] <= iMCUData;
        if (we && is_hram)     hram[a[6:0]] <= iMCUData;
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            rdata    <= 8'hFF;
            boot_dis <= 1'b0;
            ie       <= 8'h00;
            page     <= 8'h00;
            cnt      <= 8'h00;
            dma_byte <= 8'h00;
            state    <= IDLE;
        end else begin
            rdata <= rd_next;
            if (cpu_we && is_bootreg && iMCUData != 8'h00) boot_dis <= 1'b1;
            if (we && is_ie) ie <= iMCUData;
            case (state)
                RD: begin
                    dma_byte <= src_data;
                    state    <= WR;
                end
                WR: begin
                    if (cnt == 8'(DMA_LEN - 1)) begin
                        cnt   <= 8'h00;
                        state <= IDLE;
                    end else begin
                        cnt   <= cnt + 8'h01;
                        state <= RD;
                    end
                end
                default: ;
            endcase
            // A page write (re)starts the transfer, abandoning any one in flight.
            if (we && is_dmareg) begin
                page  <= iMCUData;
                cnt   <= 8'h00;
                state <= RD;
            end
        end
    end
endmodule
